// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: req/ack instruction bus, single-entry fetch buffer, CP0 redirect kill.
// Optional macro IF_FETCH_PERF_EN adds saturating wait/kill performance counters.
module if_fetch_ctrl #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] IM_BASE        = 32'h0000_3000,
    parameter int          IM_SIZE_WORDS  = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        id_stall,
    input  logic        redirect,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        pc_en,
    output logic        if_stall,
    output logic        if_clr,
    output logic [31:0] fetch_code,
    output logic        fetch_valid,
    output logic        fetch_exc,
    output logic [4:0]  fetch_exccode
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_wait_cnt,
    output logic [31:0] perf_kill_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;

    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [32:0] IM_LO    = {1'b0, IM_BASE};
    localparam logic [32:0] IM_HI    = IM_LO + 33'(4 * IM_SIZE_WORDS);
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_IBE  = 5'd6;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg;
    logic [31:0] code_reg;
    logic        valid_reg;
    logic        exc_reg;
    logic [4:0]  exccode_reg;

    logic        consume;
    logic        pc_bad;
    logic        idle_go;
    logic        timed_out;
    logic        load_en;
    logic [31:0] load_code;
    logic        load_exc;
    logic [4:0]  load_exccode;

    assign consume   = valid_reg & ~id_stall & ~redirect;
    assign pc_bad    = (pc[1:0] != 2'b00) || ({1'b0, pc} < IM_LO) || ({1'b0, pc} >= IM_HI);
    // IDLE only issues from an empty buffer, so a consume always costs one extra cycle for pc to settle
    assign idle_go   = (state_reg == IDLE) & ~valid_reg & ~redirect;
    assign timed_out = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = 8'd0;
                if (idle_go && !pc_bad) state_next = REQ;
            end
            REQ: begin
                if (!timed_out) cnt_next = cnt_reg + 8'd1;
                if (bus_ack)        state_next = IDLE;
                else if (redirect)  state_next = KILL;
                else if (timed_out) state_next = IDLE;
            end
            KILL: begin
                if (!timed_out) cnt_next = cnt_reg + 8'd1;
                if (bus_ack || timed_out) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_req      = (state_reg == REQ);
        pc_en        = reset ? 1'b0 : (consume | redirect);
        if_stall     = reset ? 1'b0 : id_stall;
        if_clr       = reset ? 1'b1 : (redirect | (~valid_reg & ~id_stall));
        load_en      = 1'b0;
        load_code    = 32'd0;
        load_exc     = 1'b0;
        load_exccode = 5'd0;
        case (state_reg)
            IDLE: begin
                if (idle_go && pc_bad) begin
                    load_en      = 1'b1;
                    load_exc     = 1'b1;
                    load_exccode = EXC_ADEL;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    load_en   = 1'b1;
                    load_code = bus_rdata;
                end else if (!redirect && timed_out) begin
                    load_en      = 1'b1;
                    load_exc     = 1'b1;
                    load_exccode = EXC_IBE;
                end
            end
            default: load_en = 1'b0;
        endcase
    end

    // Redirect outranks any same-cycle load, which in turn can only happen into an empty buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg    <= 32'd0;
            valid_reg   <= 1'b0;
            exc_reg     <= 1'b0;
            exccode_reg <= 5'd0;
            code_reg    <= 32'd0;
        end else begin
            if (idle_go && !pc_bad) addr_reg <= pc;
            if (redirect || (!load_en && consume)) begin
                valid_reg   <= 1'b0;
                exc_reg     <= 1'b0;
                exccode_reg <= 5'd0;
                code_reg    <= 32'd0;
            end else if (load_en) begin
                valid_reg   <= 1'b1;
                exc_reg     <= load_exc;
                exccode_reg <= load_exccode;
                code_reg    <= load_code;
            end
        end
    end

    assign bus_addr      = addr_reg;
    assign fetch_code    = code_reg;
    assign fetch_valid   = valid_reg;
    assign fetch_exc     = exc_reg;
    assign fetch_exccode = exccode_reg;

`ifdef IF_FETCH_PERF_EN
    logic        perf_wait_evt;
    logic        perf_kill_evt;
    logic [31:0] perf_wait_reg;
    logic [31:0] perf_kill_reg;

    assign perf_wait_evt = (state_reg != IDLE);
    // Redirect in REQ is either a move to KILL or, with a same-cycle ack, a dropped response
    assign perf_kill_evt = (state_reg == REQ) & redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_wait_reg <= 32'd0;
            perf_kill_reg <= 32'd0;
        end else begin
            if (perf_wait_evt && perf_wait_reg != 32'hFFFF_FFFF) perf_wait_reg <= perf_wait_reg + 32'd1;
            if (perf_kill_evt && perf_kill_reg != 32'hFFFF_FFFF) perf_kill_reg <= perf_kill_reg + 32'd1;
        end
    end

    assign perf_wait_cnt = perf_wait_reg;
    assign perf_kill_cnt = perf_kill_reg;
`endif

endmodule
